// File: rtl/line_fill_ctrl_if.sv
// rtl/line_fill_ctrl_if.sv - AHB-Lite read-master bus used by the line-fill engine
interface line_fill_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic [2:0]        hburst;
    logic [2:0]        hsize;
    logic              hwrite;
    logic              hready;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;

    modport master (
        output haddr, htrans, hburst, hsize, hwrite,
        input  hready, hrdata, hresp
    );

    modport slave (
        input  haddr, htrans, hburst, hsize, hwrite,
        output hready, hrdata, hresp
    );
endinterface

// File: rtl/line_fill_ctrl.sv
// rtl/line_fill_ctrl.sv - I-cache line refill engine; CRIT_WORD_FIRST_EN selects WRAP4 critical-word-first, else INCR4 from word 0
module line_fill_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              hclk,
    input  logic              hrstn,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              crit_valid,
    output logic [DATA_W-1:0] crit_data,
    output logic              fill_valid,
    output logic [LINE_W-1:0] fill_line,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              fill_err,
    line_fill_ctrl_if.master  ahb
);
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;
    localparam logic [2:0] BEATS     = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_ERR} state_t;

    state_t             state, next_state;
    logic [ADDR_W-5:0]  base_addr;
    logic [1:0]         crit_word;
    logic [2:0]         addr_cnt, data_cnt;
    logic               err_seen;
    logic               crit_valid_q;
    logic [DATA_W-1:0]  crit_data_q;
    logic [LINE_W-1:0]  line_q;
    logic [1:0]         start_word, addr_off, data_off;
    logic               addr_phase, data_phase, beat_ok, err_first, accept;
    logic [1:0]         unused_addr_bits;

`ifdef CRIT_WORD_FIRST_EN
    assign start_word = crit_word;
    assign ahb.hburst = 3'b010;
`else
    assign start_word = 2'b00;
    assign ahb.hburst = 3'b011;
`endif

    assign unused_addr_bits = req_addr[1:0];

    // Offsets wrap mod 4 inside the 16-byte block for both burst kinds.
    assign addr_off  = start_word + addr_cnt[1:0];
    assign data_off  = start_word + data_cnt[1:0];

    assign ahb.haddr  = {base_addr, addr_off, 2'b00};
    assign ahb.hsize  = 3'b010;
    assign ahb.hwrite = 1'b0;

    assign req_ready  = (state == S_IDLE);
    assign fill_valid = (state == S_DONE);
    assign fill_err   = (state == S_ERR);
    assign fill_line  = line_q;
    assign fill_addr  = {base_addr, 4'b0000};
    assign crit_valid = crit_valid_q;
    assign crit_data  = crit_data_q;

    always_comb begin
        addr_phase = 1'b0;
        data_phase = 1'b0;
        ahb.htrans = HT_IDLE;
        next_state = state;
        accept     = 1'b0;
        beat_ok    = 1'b0;
        err_first  = 1'b0;
        case (state)
            S_IDLE: begin
                accept = req_valid;
                if (req_valid) next_state = S_ADDR;
            end
            S_ADDR: begin
                addr_phase = 1'b1;
                ahb.htrans = HT_NONSEQ;
                if (ahb.hready) next_state = S_DATA;
            end
            S_DATA: begin
                // A first ERROR cycle cancels all further address phases.
                addr_phase = (addr_cnt < BEATS) && !err_seen;
                data_phase = (data_cnt < addr_cnt);
                ahb.htrans = addr_phase ? HT_SEQ : HT_IDLE;
                beat_ok    = data_phase && ahb.hready && !ahb.hresp;
                err_first  = data_phase && !ahb.hready && ahb.hresp;
                if (data_phase && ahb.hready && ahb.hresp)
                    next_state = S_ERR;
                else if (beat_ok && data_cnt == BEATS - 3'd1)
                    next_state = S_DONE;
            end
            S_DONE:  next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (!hrstn) begin
            state        <= S_IDLE;
            base_addr    <= '0;
            crit_word    <= '0;
            addr_cnt     <= '0;
            data_cnt     <= '0;
            err_seen     <= 1'b0;
            crit_valid_q <= 1'b0;
            crit_data_q  <= '0;
            line_q       <= '0;
        end else begin
            state        <= next_state;
            crit_valid_q <= 1'b0;
            if (accept) begin
                base_addr <= req_addr[ADDR_W-1:4];
                crit_word <= req_addr[3:2];
                addr_cnt  <= '0;
                data_cnt  <= '0;
                err_seen  <= 1'b0;
            end
            if (addr_phase && ahb.hready && addr_cnt != BEATS)
                addr_cnt <= addr_cnt + 3'd1;
            if (err_first)
                err_seen <= 1'b1;
            if (beat_ok) begin
                line_q[32'(data_off) * DATA_W +: DATA_W] <= ahb.hrdata;
                if (data_cnt != BEATS)
                    data_cnt <= data_cnt + 3'd1;
                if (data_off == crit_word) begin
                    crit_valid_q <= 1'b1;
                    crit_data_q  <= ahb.hrdata;
                end
            end
        end
    end
endmodule
